// File: rtl/mux_arb_pkg.sv
// Shared constants, state encoding and channel-increment helper for the 4:1 mux select arbiter.
package mux_arb_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Next channel in round-robin order; channel 3 wraps to 0 through the SEL_W-bit result.
  function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] ch);
    return ch + 1'b1;
  endfunction

endpackage

// File: rtl/mux_select_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo NUM_CH.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic              any,
  output logic [SEL_W-1:0]  idx,
  output logic [NUM_CH-1:0] onehot
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    any    = |req;
    idx    = '0;
    cand   = '0;
    onehot = '0;
    // Walk from lowest to highest priority so the last hit is the winner.
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) idx = cand;
    end
    if (any) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/mux_select_arbiter.sv
// Round-robin arbiter driving the 4:1 mux select lines with a valid/ready handshake.
// Optional stall timeout enabled by defining MUX_ARB_TIMEOUT_EN.
module mux_select_arbiter
  import mux_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic              out_ready,
  output logic              out_valid,
  output logic              address0,
  output logic              address1,
  output logic [NUM_CH-1:0] grant,
  output logic              timeout
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e            state_q;
  logic [SEL_W-1:0]  ptr_q;
  logic [SEL_W-1:0]  sel_q;
  logic              vld_q;
  logic [NUM_CH-1:0] grant_q;

  logic              handshake;
  logic [SEL_W-1:0]  pick_ptr_d;
  logic              pick_any;
  logic [SEL_W-1:0]  pick_idx;
  logic [NUM_CH-1:0] pick_onehot;

  // On a handshake the picker already sees the advanced pointer, enabling back-to-back grants.
  assign handshake  = (state_q == ST_GRANT) && out_ready;
  assign pick_ptr_d = handshake ? next_ch(sel_q) : ptr_q;

  rr_pick u_pick (
    .req    (req),
    .ptr    (pick_ptr_d),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] stall_cnt_q;
  logic             timeout_q;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      sel_q       <= '0;
      vld_q       <= 1'b0;
      grant_q     <= '0;
`ifdef MUX_ARB_TIMEOUT_EN
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
`ifdef MUX_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            state_q <= ST_GRANT;
            vld_q   <= 1'b1;
            sel_q   <= pick_idx;
            grant_q <= pick_onehot;
`ifdef MUX_ARB_TIMEOUT_EN
            stall_cnt_q <= '0;
`endif
          end
        end
        ST_GRANT: begin
          if (out_ready) begin
            ptr_q <= next_ch(sel_q);
`ifdef MUX_ARB_TIMEOUT_EN
            stall_cnt_q <= '0;
`endif
            if (pick_any) begin
              sel_q   <= pick_idx;
              grant_q <= pick_onehot;
            end else begin
              state_q <= ST_IDLE;
              vld_q   <= 1'b0;
              sel_q   <= '0;
              grant_q <= '0;
            end
          end
`ifdef MUX_ARB_TIMEOUT_EN
          else if (stall_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // Abandon the stalled grant; the winner drops to lowest priority.
            timeout_q   <= 1'b1;
            state_q     <= ST_IDLE;
            vld_q       <= 1'b0;
            sel_q       <= '0;
            grant_q     <= '0;
            ptr_q       <= next_ch(sel_q);
            stall_cnt_q <= '0;
          end else begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = vld_q;
  assign address0  = sel_q[1];
  assign address1  = sel_q[0];
  assign grant     = grant_q;

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Randomized and directed bench for mux_select_arbiter against a round-robin reference model.
module tb_mux_select_arbiter;

  localparam int TO = 4;
`ifdef MUX_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int STALL4 = TO_EN ? (TO - 1) : 5;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       out_ready;
  logic       out_valid;
  logic       address0;
  logic       address1;
  logic [3:0] grant;
  logic       timeout;

  logic [7:0] in_data [4];

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state, in plain integers.
  int m_valid, m_idx, m_ptr, m_stall, m_timeout;

  always #5 clk = ~clk;

  mux_select_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .address0  (address0),
    .address1  (address1),
    .grant     (grant),
    .timeout   (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int rr_winner(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic r, input logic [3:0] rq, input logic rd);
    if (r) begin
      m_valid = 0; m_idx = 0; m_ptr = 0; m_stall = 0; m_timeout = 0;
    end else begin
      m_timeout = 0;
      if (m_valid == 0) begin
        if (rq != 4'b0) begin
          m_idx = rr_winner(rq, m_ptr); m_valid = 1; m_stall = 0;
        end
      end else if (rd) begin
        m_ptr = (m_idx + 1) % 4;
        m_stall = 0;
        if (rq != 4'b0) m_idx = rr_winner(rq, m_ptr);
        else m_valid = 0;
      end else begin
        m_stall++;
        if (TO_EN && m_stall == TO) begin
          m_timeout = 1; m_valid = 0; m_ptr = (m_idx + 1) % 4; m_stall = 0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [7:0] mux_out;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("grant", 32'(grant), m_valid != 0 ? (32'd1 << m_idx) : 32'd0);
    chk("address", 32'({address0, address1}), m_valid != 0 ? 32'(m_idx) : 32'd0);
    chk("timeout", 32'(timeout), 32'(m_timeout));
    if (m_valid != 0) begin
      mux_out = in_data[{address0, address1}];
      chk("mux_out", 32'(mux_out), 32'(in_data[m_idx]));
    end
  endtask

  task automatic step(input logic r, input logic [3:0] rq, input logic rd);
    reset = r; req = rq; out_ready = rd;
    for (int i = 0; i < 4; i++) in_data[i] = 8'($urandom);
    @(posedge clk);
    model_edge(r, rq, rd);
    #1;
    check_outputs();
  endtask

  initial begin
    logic [3:0] exp_seq [5];
    reset = 1'b1; req = 4'b1111; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) in_data[i] = 8'h00;
    m_valid = 0; m_idx = 0; m_ptr = 0; m_stall = 0; m_timeout = 0;
    #1;

    // Reset with all requests raised
    step(1'b1, 4'b1111, 1'b0);
    step(1'b1, 4'b1111, 1'b0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_addr", 32'({address0, address1}), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);

    // Single request on channel 2
    step(1'b0, 4'b0100, 1'b1);
    chk("t2_grant", 32'(grant), 32'b0100);
    chk("t2_addr", 32'({address0, address1}), 32'b10);
    chk("t2_mux", 32'(in_data[{address0, address1}]), 32'(in_data[2]));
    step(1'b0, 4'b0000, 1'b1);
    chk("t2_idle", 32'(out_valid), 32'd0);

    // Full rotation at full throughput
    step(1'b1, 4'b0000, 1'b0);
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'b1111, 1'b1);
      chk("t3_grant", 32'(grant), 32'(exp_seq[i]));
      chk("t3_valid", 32'(out_valid), 32'd1);
    end

    // Stall holds the selection, then wrap on handshake
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b0010, 1'b0);
    for (int i = 0; i < STALL4; i++) begin
      step(1'b0, 4'b0010, 1'b0);
      chk("t4_hold_grant", 32'(grant), 32'b0010);
      chk("t4_hold_addr", 32'({address0, address1}), 32'b01);
    end
    step(1'b0, 4'b0011, 1'b1);
    chk("t4_wrap", 32'(grant), 32'b0001);

    // Reset wins over a simultaneous handshake
    step(1'b1, 4'b1111, 1'b1);
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_grant", 32'(grant), 32'd0);
    step(1'b0, 4'b1010, 1'b0);
    chk("t5_regrant", 32'(grant), 32'b0010);

`ifdef MUX_ARB_TIMEOUT_EN
    // Stall timeout and re-grant of the lone requester
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b1000, 1'b0);
    for (int i = 0; i < TO - 1; i++) begin
      step(1'b0, 4'b1000, 1'b0);
      chk("t6_no_timeout", 32'(timeout), 32'd0);
    end
    step(1'b0, 4'b1000, 1'b0);
    chk("t6_timeout", 32'(timeout), 32'd1);
    chk("t6_valid", 32'(out_valid), 32'd0);
    step(1'b0, 4'b1000, 1'b0);
    chk("t6_pulse", 32'(timeout), 32'd0);
    chk("t6_regrant", 32'(grant), 32'b1000);
`else
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b1000, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 4'b1000, 1'b0);
    chk("hold_forever", 32'(grant), 32'b1000);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), 4'($urandom),
           ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
